// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared single-precision constants, FSM states and the
//               unpacked-float type for the add/subtract sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;
    localparam int FP_W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W    = MAN_W + 2;
    localparam int SH_W     = $clog2(SIG_W);
    localparam int EXP_MAX  = (1 << EXP_W) - 1;

    localparam logic [FP_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // man is the working significand: carry, hidden bit, stored fraction
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] man;
    } ufloat_t;

    // Zero exponents flush to zero: denormals are not supported
    function automatic ufloat_t fp_unpack(input logic [FP_W-1:0] f);
        ufloat_t u;
        u.sign = f[FP_W-1];
        u.exp  = f[FP_W-2 -: EXP_W];
        u.man  = (u.exp == '0) ? '0 : {1'b0, 1'b1, f[MAN_W-1:0]};
        return u;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lz_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : fp_lz_normalizer
// Description : Combinational leading-zero normaliser; shifts the significand
//               left until the hidden-bit position is set.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_lz_normalizer
    import fp_pkg::*;
(
    input  logic [SIG_W-1:0] i_sig,
    output logic [SIG_W-1:0] o_sig,
    output logic [SH_W-1:0]  o_shift
);

    // The carry bit is handled by the caller before this shift is used
    logic w_unused_carry;
    assign w_unused_carry = i_sig[SIG_W-1];

    always_comb begin
        o_shift = '0;
        for (int i = 0; i < SIG_W - 1; i++) begin
            if (i_sig[i]) begin
                o_shift = SH_W'(SIG_W - 2 - i);
            end
        end
    end

    assign o_sig = i_sig << o_shift;

endmodule
`default_nettype wire

// File: rtl/fp_addsub_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub_sequencer
// Description : Multi-cycle single-precision add/subtract with valid/ready
//               handshakes; align -> add -> normalise -> pack, truncating.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_sequencer
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] op_a,
    input  logic [FP_W-1:0] op_b,
    input  logic            op_sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] result,
    output logic            busy
);

    state_t           r_state;
    state_t           w_state_next;

    logic [FP_W-1:0]  r_a;
    logic [FP_W-1:0]  r_b;
    logic             r_sign;
    logic             r_eff_sub;
    logic             r_special;
    logic [FP_W-1:0]  r_special_val;
    logic [EXP_W-1:0] r_exp;
    logic [SIG_W-1:0] r_ma;
    logic [SIG_W-1:0] r_mb;
    logic [SIG_W-1:0] r_ms;
    logic [FP_W-1:0]  r_result;

    // ---------------- align stage ----------------
    ufloat_t          w_ua;
    ufloat_t          w_ub;
    ufloat_t          w_big;
    ufloat_t          w_small;
    logic             w_swap;
    logic [EXP_W-1:0] w_diff;
    logic [SIG_W-1:0] w_mb_aligned;

    assign w_ua   = fp_unpack(r_a);
    assign w_ub   = fp_unpack(r_b);
    assign w_swap = {w_ub.exp, w_ub.man} > {w_ua.exp, w_ua.man};
    assign w_big   = w_swap ? w_ub : w_ua;
    assign w_small = w_swap ? w_ua : w_ub;
    assign w_diff  = w_big.exp - w_small.exp;
    assign w_mb_aligned = (w_diff >= EXP_W'(SIG_W)) ? '0 : (w_small.man >> w_diff);

    logic w_a_emax, w_b_emax, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic             w_special;
    logic [FP_W-1:0]  w_special_val;

    assign w_a_emax = &r_a[FP_W-2 -: EXP_W];
    assign w_b_emax = &r_b[FP_W-2 -: EXP_W];
    assign w_a_nan  = w_a_emax && (|r_a[MAN_W-1:0]);
    assign w_b_nan  = w_b_emax && (|r_b[MAN_W-1:0]);
    assign w_a_inf  = w_a_emax && !(|r_a[MAN_W-1:0]);
    assign w_b_inf  = w_b_emax && !(|r_b[MAN_W-1:0]);

    always_comb begin
        w_special     = 1'b1;
        w_special_val = QNAN;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a[FP_W-1] != r_b[FP_W-1]))) begin
            w_special_val = QNAN;
        end else if (w_a_inf) begin
            w_special_val = {r_a[FP_W-1], POS_INF[FP_W-2:0]};
        end else if (w_b_inf) begin
            w_special_val = {r_b[FP_W-1], POS_INF[FP_W-2:0]};
        end else begin
            w_special     = 1'b0;
            w_special_val = '0;
        end
    end

    // ---------------- normalise / pack stage ----------------
    logic [SIG_W-1:0] w_norm_sig;
    logic [SH_W-1:0]  w_shift;
    logic [EXP_W:0]   w_exp_inc;
    logic [EXP_W+1:0] w_exp_dec;
    logic [SIG_W-1:0] w_sig_sel;
    logic [FP_W-1:0]  w_packed;
    logic [SIG_W-MAN_W-1:0] w_unused_sig;

    fp_lz_normalizer u_lz_normalizer (
        .i_sig   (r_ms),
        .o_sig   (w_norm_sig),
        .o_shift (w_shift)
    );

    assign w_exp_inc    = {1'b0, r_exp} + (EXP_W+1)'(1);
    // two's complement: the top bit flags an exponent that went below zero
    assign w_exp_dec    = {2'b00, r_exp} - {{(EXP_W+2-SH_W){1'b0}}, w_shift};
    assign w_unused_sig = w_sig_sel[SIG_W-1:MAN_W];

    always_comb begin
        w_sig_sel = w_norm_sig;
        w_packed  = '0;
        if (r_special) begin
            w_packed = r_special_val;
        end else if (r_ms[SIG_W-1]) begin
            w_sig_sel = r_ms >> 1;
            if (w_exp_inc >= (EXP_W+1)'(EXP_MAX)) begin
                w_packed = {r_sign, POS_INF[FP_W-2:0]};
            end else begin
                w_packed = {r_sign, w_exp_inc[EXP_W-1:0], w_sig_sel[MAN_W-1:0]};
            end
        end else if (r_ms == '0) begin
            w_packed = '0;
        end else if (w_exp_dec[EXP_W+1] || (w_exp_dec == '0)) begin
            w_packed = {r_sign, {(FP_W-1){1'b0}}};
        end else begin
            w_packed = {r_sign, w_exp_dec[EXP_W-1:0], w_sig_sel[MAN_W-1:0]};
        end
    end

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = ALIGN;
                end
            end
            ALIGN: w_state_next = ADD;
            ADD:   w_state_next = NORM;
            NORM:  w_state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a           <= '0;
            r_b           <= '0;
            r_sign        <= 1'b0;
            r_eff_sub     <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_exp         <= '0;
            r_ma          <= '0;
            r_mb          <= '0;
            r_ms          <= '0;
            r_result      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a <= op_a;
                        r_b <= op_b ^ {op_sub, {(FP_W-1){1'b0}}};
                    end
                end
                ALIGN: begin
                    r_sign        <= w_big.sign;
                    r_exp         <= w_big.exp;
                    r_ma          <= w_big.man;
                    r_mb          <= w_mb_aligned;
                    r_eff_sub     <= w_big.sign ^ w_small.sign;
                    r_special     <= w_special;
                    r_special_val <= w_special_val;
                end
                // magnitude ordering guarantees the difference is non-negative
                ADD:  r_ms     <= r_eff_sub ? (r_ma - r_mb) : (r_ma + r_mb);
                NORM: r_result <= w_packed;
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire
